dq_search_ctrl: RTL and testbench
=================================

DQ_SEARCH_CTRL -- requirements
Module: dq_search_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N, 32, datapath word width
- NUM_VALUES, 16, candidates issued per search; fixed at 16
- PRE_CYCLES, 35, cycles Rq_out/Dh_out are held stable before the first issue
- TIMEOUT, 255, maximum WAIT cycles before error
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock
- rst, in, 1, synchronous, active-high reset
- start, in, 1, request one search
- Rq_in, in, N signed, Rq operand
- Dh_in, in, N signed, Dh operand
- dp_busy, in, 1, datapath min-finder busy
- dp_min_valid, in, 1, datapath result strobe
- dp_dq_min, in, N signed, datapath minimum dq
- dp_q_min, in, 5, datapath index of minimum
- Rq_out, out, N signed, held Rq to datapath
- Dh_out, out, N signed, held Dh to datapath
- m_dI1, m_dI2, m_dQ1, m_dQ2, out, 3 signed each, candidate symbols
- invDh_valid, out, 1, candidate valid to datapath
- busy, out, 1, search in progress
- done, out, 1, one-cycle result pulse
- timeout_err, out, 1, one-cycle error pulse
- res_dq_min, out, N signed, captured minimum
- res_q_min, out, 5, captured index
REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, PRELOAD, ISSUE, WAIT, DONE and ERR, one-hot or binary, with IDLE on reset.
REQ-005 In IDLE, start=1 with dp_busy=0 SHALL latch Rq_in/Dh_in into Rq_out/Dh_out and go to PRELOAD; start with dp_busy=1 SHALL be ignored (no latch).
REQ-006 start outside IDLE SHALL be ignored; it is not queued.
REQ-007 PRELOAD SHALL last exactly PRE_CYCLES cycles, then go to ISSUE; invDh_valid=0 throughout.
REQ-008 ISSUE SHALL last exactly NUM_VALUES cycles with invDh_valid=1, index q counting 0..15, one per cycle.
REQ-009 Candidate mapping per q: m_dI1 = q[0] ? +1 : -1; m_dI2 from q[1]; m_dQ1 from q[2]; m_dQ2 from q[3]; outside ISSUE all m_* = 0.
REQ-010 After q=15, the FSM SHALL go to WAIT; the WAIT counter starts at 0 and increments every WAIT cycle.
REQ-011 dp_min_valid=1 in WAIT SHALL capture dp_dq_min to res_dq_min and dp_q_min to res_q_min, then go to DONE.
REQ-012 If the WAIT counter reaches TIMEOUT without dp_min_valid, the FSM SHALL go to ERR; results SHALL be unchanged.
REQ-013 If dp_min_valid and the timeout occur in the same cycle, capture SHALL take priority (go to DONE).
REQ-014 dp_min_valid outside WAIT SHALL be ignored.
REQ-015 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE; ERR SHALL assert timeout_err=1 for exactly one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE; start is accepted again in the first IDLE cycle after DONE or ERR.
REQ-017 Rq_out and Dh_out SHALL stay constant from the latch until the next accepted start.
REQ-018 Latency: with start accepted at edge T, first invDh_valid is at cycle T+1+PRE_CYCLES, and the last is at T+PRE_CYCLES+16.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 With rst=1 at an edge, all outputs SHALL be 0, the FSM SHALL enter IDLE, and q and the WAIT counter SHALL clear.
REQ-021 Reset mid-search (any state) SHALL abort it: invDh_valid=0 the next cycle, and no done or timeout_err pulse.

Verification
REQ-022 start with Rq_in=0x00400000, Dh_in=0x00200000, dp_busy=0 -> invDh_valid high for cycles 36..51 after start; m_* sequence -1,-1,-1,-1 then +1,-1,-1,-1 ... ending +1,+1,+1,+1.
REQ-023 dp_min_valid in WAIT cycle 10 with dp_dq_min=0x00012345 and dp_q_min=7 -> res_dq_min=0x00012345 and res_q_min=7; done pulses once the next cycle; busy=0 after.
REQ-024 No dp_min_valid -> timeout_err pulses once, 255 WAIT cycles after entry; res_* hold their previous values.
REQ-025 Re-pulse start during ISSUE, and start with dp_busy=1 in IDLE -> both ignored; Rq_out/Dh_out unchanged.
REQ-026 rst asserted at the 5th ISSUE cycle -> all outputs 0 next cycle; a fresh start then runs a full, correct search.
REQ-027 dp_min_valid coincident with the timeout cycle -> done pulses, timeout_err stays 0.

Source files
------------

// File: rtl/dq_search_ctrl.sv
// dq_search_ctrl: sequences one dq minimum search. It holds Rq/Dh stable for a
// preload window, issues the 16 candidate symbol sets, waits for the datapath
// minimum, and reports either a one-cycle done pulse or a one-cycle timeout.
// Every output comes straight from a register. Each output register loads a
// value computed from the next state, so outputs line up with the FSM state.
module dq_search_ctrl #(
    parameter int N          = 32,
    parameter int NUM_VALUES = 16,
    parameter int PRE_CYCLES = 35,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] Rq_in,
    input  logic signed [N-1:0] Dh_in,
    input  logic                dp_busy,
    input  logic                dp_min_valid,
    input  logic signed [N-1:0] dp_dq_min,
    input  logic [4:0]          dp_q_min,
    output logic signed [N-1:0] Rq_out,
    output logic signed [N-1:0] Dh_out,
    output logic signed [2:0]   m_dI1,
    output logic signed [2:0]   m_dI2,
    output logic signed [2:0]   m_dQ1,
    output logic signed [2:0]   m_dQ2,
    output logic                invDh_valid,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic signed [N-1:0] res_dq_min,
    output logic [4:0]          res_q_min
);

    // One counter serves both the preload window and the WAIT timeout.
    localparam int CNT_MAX = (PRE_CYCLES > TIMEOUT) ? PRE_CYCLES : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int QW      = $clog2(NUM_VALUES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            capture;

    // Output register next values
    logic                invdh_d, busy_d, done_d, err_d;
    logic [2:0]          m_d [4];
    logic [N-1:0]        rq_d, dh_d, res_dq_d;
    logic [4:0]          res_q_d;

    logic                invdh_q, busy_q, done_q, err_q;
    logic [2:0]          m_q [4];
    logic [N-1:0]        rq_q, dh_q, res_dq_q;
    logic [4:0]          res_q_q;

    // State register with the index and cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: phase sequencing, start acceptance and result capture
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start is dropped while the datapath is still busy.
                if (start && !dp_busy) begin
                    accept  = 1'b1;
                    state_d = S_PRELOAD;
                    cnt_d   = '0;
                end
            end
            S_PRELOAD: begin
                if (cnt_q == CW'(PRE_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    q_d     = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ISSUE: begin
                if (q_q == QW'(NUM_VALUES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    q_d = q_q + QW'(1);
                end
            end
            S_WAIT: begin
                // A result arriving in the final WAIT cycle still wins over the timeout.
                if (dp_min_valid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                q_d     = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                q_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Candidate symbols: bit k of the issue index selects +1 or -1 for symbol k
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            assign m_d[gi] = (state_d != S_ISSUE) ? 3'b000 :
                             (q_d[gi] ? 3'b001 : 3'b111);
        end
    endgenerate

    // Output logic: values each output register loads at the next edge
    always_comb begin
        invdh_d  = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        err_d    = (state_d == S_ERR);
        rq_d     = accept ? Rq_in : rq_q;
        dh_d     = accept ? Dh_in : dh_q;
        res_dq_d = capture ? dp_dq_min : res_dq_q;
        res_q_d  = capture ? dp_q_min : res_q_q;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            invdh_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rq_q     <= '0;
            dh_q     <= '0;
            res_dq_q <= '0;
            res_q_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                m_q[i] <= 3'b000;
            end
        end else begin
            invdh_q  <= invdh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rq_q     <= rq_d;
            dh_q     <= dh_d;
            res_dq_q <= res_dq_d;
            res_q_q  <= res_q_d;
            for (int i = 0; i < 4; i++) begin
                m_q[i] <= m_d[i];
            end
        end
    end

    assign Rq_out      = rq_q;
    assign Dh_out      = dh_q;
    assign m_dI1       = m_q[0];
    assign m_dI2       = m_q[1];
    assign m_dQ1       = m_q[2];
    assign m_dQ2       = m_q[3];
    assign invDh_valid = invdh_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign res_dq_min  = res_dq_q;
    assign res_q_min   = res_q_q;

endmodule

// File: tb/tb_dq_search_ctrl.sv
// Bench for dq_search_ctrl: table of whole-search vectors, a mid-search reset
// sequence, and a random phase. A cycle-level reference model compares every
// output on every cycle. The model tracks the elapsed cycles since the
// accepted start.
module tb_dq_search_ctrl;

    localparam int N       = 32;
    localparam int PRE     = 35;
    localparam int TMO     = 255;
    localparam int ISS0    = PRE + 1;      // first ISSUE cycle after accept
    localparam int WAIT0   = PRE + 17;     // first WAIT cycle after accept

    logic         clk = 1'b0;
    logic         rst, start, dp_busy, dp_min_valid;
    logic [N-1:0] Rq_in, Dh_in, dp_dq_min;
    logic [4:0]   dp_q_min;
    logic [N-1:0] rq_out, dh_out, res_dq;
    logic [2:0]   mi1, mi2, mq1, mq2;
    logic         inv, busy, done, terr;
    logic [4:0]   res_q;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dq_search_ctrl #(.N(N), .NUM_VALUES(16), .PRE_CYCLES(PRE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .Rq_in(Rq_in), .Dh_in(Dh_in),
        .dp_busy(dp_busy), .dp_min_valid(dp_min_valid), .dp_dq_min(dp_dq_min),
        .dp_q_min(dp_q_min), .Rq_out(rq_out), .Dh_out(dh_out),
        .m_dI1(mi1), .m_dI2(mi2), .m_dQ1(mq1), .m_dQ2(mq2),
        .invDh_valid(inv), .busy(busy), .done(done), .timeout_err(terr),
        .res_dq_min(res_dq), .res_q_min(res_q)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 searching (md_c = cycles since accept),
    // 2 done pulse cycle, 3 timeout pulse cycle.
    int           md_mode = 0;
    int           md_c    = 0;
    logic [N-1:0] md_rq = '0, md_dh = '0, md_res_dq = '0;
    logic [4:0]   md_res_q = '0;

    task automatic model_edge();
        if (rst) begin
            md_mode = 0; md_c = 0;
            md_rq = '0; md_dh = '0; md_res_dq = '0; md_res_q = '0;
        end else begin
            case (md_mode)
                0: if (start && !dp_busy) begin
                       md_mode = 1; md_c = 1; md_rq = Rq_in; md_dh = Dh_in;
                   end
                1: if (md_c >= WAIT0 && dp_min_valid) begin
                       md_mode = 2; md_res_dq = dp_dq_min; md_res_q = dp_q_min;
                   end else if (md_c == WAIT0 + TMO - 1) begin
                       md_mode = 3;
                   end else begin
                       md_c = md_c + 1;
                   end
                default: md_mode = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_m(input int k);
        int q;
        if (!(md_mode == 1 && md_c >= ISS0 && md_c < ISS0 + 16)) return 3'b000;
        q = md_c - ISS0;
        return ((q >> k) & 1) != 0 ? 3'b001 : 3'b111;
    endfunction

    task automatic compare_all();
        logic e_inv;
        e_inv = (md_mode == 1 && md_c >= ISS0 && md_c < ISS0 + 16);
        chk("busy",        N'(busy), N'(md_mode != 0));
        chk("done",        N'(done), N'(md_mode == 2));
        chk("timeout_err", N'(terr), N'(md_mode == 3));
        chk("invDh_valid", N'(inv),  N'(e_inv));
        chk("m_dI1", N'(mi1), N'(exp_m(0)));
        chk("m_dI2", N'(mi2), N'(exp_m(1)));
        chk("m_dQ1", N'(mq1), N'(exp_m(2)));
        chk("m_dQ2", N'(mq2), N'(exp_m(3)));
        chk("Rq_out", rq_out, md_rq);
        chk("Dh_out", dh_out, md_dh);
        chk("res_dq_min", res_dq, md_res_dq);
        chk("res_q_min", N'(res_q), N'(md_res_q));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    typedef struct {
        logic         dpb;          // dp_busy while start is presented
        int           dpv_w;        // WAIT index of dp_min_valid, -1 = never
        logic [N-1:0] dq;
        logic [4:0]   qm;
        logic [N-1:0] rq, dh;
        bit           exp_accept;
        int           exp_pulse;    // cycle (after accept) of done/timeout pulse
        bit           exp_done;
        logic [N-1:0] exp_res_dq;
        logic [4:0]   exp_res_q;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input int idx);
        int c = 1, first_inv = -1, last_inv = -1, pulse = -1, n_done = 0, n_err = 0;
        logic [N-1:0] rq_before;
        rq_before = rq_out;
        Rq_in = v.rq; Dh_in = v.dh; dp_busy = v.dpb; start = 1'b1;
        tick();
        start = 1'b0; dp_busy = 1'b0;
        if (!v.exp_accept) begin
            repeat (3) tick();
            chk($sformatf("v%0d_busy_ignored", idx), N'(busy), '0);
            chk($sformatf("v%0d_rq_hold", idx), rq_out, rq_before);
            $display("vec %0d: start with dp_busy=1, rq_out=%h", idx, rq_out);
            return;
        end
        while (c <= 340) begin
            if (inv) begin
                if (first_inv < 0) first_inv = c;
                last_inv = c;
            end
            if (done) begin n_done++; if (pulse < 0) pulse = c; end
            if (terr) begin n_err++; if (pulse < 0) pulse = c; end
            if (!busy) break;
            // Stray result strobe during PRELOAD and a re-pulsed start during ISSUE.
            dp_min_valid = (c == 20) || (v.dpv_w >= 0 && c == WAIT0 + v.dpv_w);
            dp_dq_min = (c == 20) ? 32'hDEADBEEF : v.dq;
            dp_q_min  = (c == 20) ? 5'd3 : v.qm;
            start = (c == ISS0 + 4);
            Rq_in = ~v.rq; Dh_in = ~v.dh;
            tick();
            dp_min_valid = 1'b0; start = 1'b0;
            c++;
        end
        chk($sformatf("v%0d_end_idle", idx), N'(busy), '0);
        chk($sformatf("v%0d_first_inv", idx), N'(first_inv), N'(ISS0));
        chk($sformatf("v%0d_last_inv", idx), N'(last_inv), N'(ISS0 + 15));
        chk($sformatf("v%0d_pulse_cycle", idx), N'(pulse), N'(v.exp_pulse));
        chk($sformatf("v%0d_done_count", idx), N'(n_done), N'(v.exp_done ? 1 : 0));
        chk($sformatf("v%0d_err_count", idx), N'(n_err), N'(v.exp_done ? 0 : 1));
        chk($sformatf("v%0d_res_dq", idx), res_dq, v.exp_res_dq);
        chk($sformatf("v%0d_res_q", idx), N'(res_q), N'(v.exp_res_q));
        chk($sformatf("v%0d_rq_out", idx), rq_out, v.rq);
        chk($sformatf("v%0d_dh_out", idx), dh_out, v.dh);
        $display("vec %0d: pulse at cycle %0d done=%0d err=%0d res=%h/%0d",
                 idx, pulse, n_done, n_err, res_dq, res_q);
    endtask

    initial begin
        // dpb dpv_w dq qm rq dh accept pulse done res_dq res_q
        vecs[0] = '{1'b0, 10, 32'h00012345, 5'd7, 32'h00400000, 32'h00200000,
                    1'b1, WAIT0 + 11, 1'b1, 32'h00012345, 5'd7};
        vecs[1] = '{1'b0, -1, 32'h0BADF00D, 5'd9, 32'h11112222, 32'h33334444,
                    1'b1, WAIT0 + TMO, 1'b0, 32'h00012345, 5'd7};
        vecs[2] = '{1'b0, TMO - 1, 32'hFFFF8000, 5'd31, 32'hFFC00000, 32'h7FFFFFFF,
                    1'b1, WAIT0 + TMO, 1'b1, 32'hFFFF8000, 5'd31};
        vecs[3] = '{1'b1, 5, 32'h00000001, 5'd1, 32'h55555555, 32'hAAAAAAAA,
                    1'b0, 0, 1'b0, 32'hFFFF8000, 5'd31};
        vecs[4] = '{1'b0, 0, 32'h80000000, 5'd0, 32'h00000001, 32'h80000001,
                    1'b1, WAIT0 + 1, 1'b1, 32'h80000000, 5'd0};
        vecs[5] = '{1'b0, 3, 32'h00000042, 5'd15, 32'h00400000, 32'h00200000,
                    1'b1, WAIT0 + 4, 1'b1, 32'h00000042, 5'd15};

        rst = 1'b1; start = 1'b0; dp_busy = 1'b0; dp_min_valid = 1'b0;
        Rq_in = '0; Dh_in = '0; dp_dq_min = '0; dp_q_min = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        $display("reset: busy=%0d inv=%0d rq_out=%h res=%h", busy, inv, rq_out, res_dq);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset on the 5th ISSUE cycle aborts the search with no pulse.
        Rq_in = 32'h01234567; Dh_in = 32'h089ABCDE; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (ISS0 + 3) tick();
        chk("midrst_inv_before", N'(inv), N'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_inv", N'(inv), '0);
        chk("midrst_busy", N'(busy), '0);
        chk("midrst_rq", rq_out, '0);
        chk("midrst_res", res_dq, '0);
        $display("mid-issue reset: inv=%0d busy=%0d rq_out=%h", inv, busy, rq_out);
        repeat (4) tick();
        run_vec(vecs[5], 5);

        // Random phase checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 599) == 0);
            start        = ($urandom_range(0, 9) == 0);
            dp_busy      = ($urandom_range(0, 3) == 0);
            dp_min_valid = ($urandom_range(0, 39) == 0);
            dp_dq_min    = $urandom();
            dp_q_min     = 5'($urandom());
            Rq_in        = $urandom();
            Dh_in        = $urandom();
            tick();
        end
        $display("random phase: %0d cycles", 4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
